// File: rtl/issue_cdb_scheduler_pkg.sv
// Shared types and sizes for the RS issue / CDB wakeup scheduler.
package issue_cdb_scheduler_pkg;
    localparam int ROB_TAG_LEN = 6;
    localparam int XLEN        = 32;
    localparam int DEF_MAX_LAT = 4;
    // Owner field is sized for the largest supported RS count; only the low RS_IDX_W bits are used.
    localparam int OWNER_W     = 8;

    typedef struct packed {
        logic               valid;
        logic [OWNER_W-1:0] owner;
    } cdb_slot_t;
endpackage

// File: rtl/issue_cdb_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr, wrapping modulo NUM_RS.
module issue_cdb_scheduler_rr_arbiter #(
    parameter int NUM_RS   = 4,
    parameter int RS_IDX_W = 2
) (
    input  logic [NUM_RS-1:0]   req,
    input  logic [RS_IDX_W-1:0] ptr,
    output logic [NUM_RS-1:0]   grant,
    output logic [RS_IDX_W-1:0] grant_idx,
    output logic                any_grant
);
    logic [RS_IDX_W-1:0] cand_idx [NUM_RS];
    logic [NUM_RS-1:0]   cand_req;

    // Candidate gi is the RS gi positions after ptr; explicit wrap keeps non power-of-2 counts correct.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RS; gi++) begin : g_cand
            logic [RS_IDX_W:0] sum;
            assign sum = {1'b0, ptr} + (RS_IDX_W+1)'(gi);
            assign cand_idx[gi] = (sum >= (RS_IDX_W+1)'(NUM_RS))
                                  ? RS_IDX_W'(sum - (RS_IDX_W+1)'(NUM_RS))
                                  : sum[RS_IDX_W-1:0];
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = NUM_RS - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                grant_idx = cand_idx[k];
                any_grant = 1'b1;
            end
        end
        if (any_grant) begin
            grant[grant_idx] = 1'b1;
        end
    end
endmodule

// File: rtl/issue_cdb_scheduler.sv
// Issue controller: round-robin RS grant with CDB slot reservation so fixed-latency results never collide.
module issue_cdb_scheduler
    import issue_cdb_scheduler_pkg::*;
#(
    parameter int NUM_RS   = 4,
    parameter int RS_IDX_W = 2,
    parameter int MAX_LAT  = DEF_MAX_LAT,
    parameter int LAT_W    = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [NUM_RS-1:0]             insn_ready,
    input  logic [NUM_RS*LAT_W-1:0]       fu_lat,
    input  logic [NUM_RS-1:0]             fu_result_valid,
    input  logic [NUM_RS*ROB_TAG_LEN-1:0] fu_result_tag,
    input  logic [NUM_RS*XLEN-1:0]        fu_result_value,
    output logic [NUM_RS-1:0]             issue,
    output logic                          wakeup,
    output logic [ROB_TAG_LEN-1:0]        wakeup_tag,
    output logic [XLEN-1:0]               wakeup_value,
    output logic [RS_IDX_W-1:0]           wakeup_src,
    output logic                          protocol_err,
    output logic [15:0]                   conflict_cnt
);
    cdb_slot_t           slot_reg  [MAX_LAT];
    cdb_slot_t           slot_next [MAX_LAT];
    logic [RS_IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [15:0]         conflict_cnt_reg;
    logic                protocol_err_reg;

    logic [LAT_W-1:0]    lat_f [NUM_RS];
    logic [NUM_RS-1:0]   lat_legal, target_busy, elig, req, grant;
    logic [RS_IDX_W-1:0] grant_idx;
    logic                any_grant;
    logic [LAT_W-1:0]    lat_g;
    logic [RS_IDX_W-1:0] head_owner;
    logic                wakeup_int, err_event, conflict_event;

    // A request with latency L lands on the slot now at position L, which shifts to L-1 at the edge.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RS; gi++) begin : g_rs
            logic busy;
            assign lat_f[gi]     = fu_lat[gi*LAT_W +: LAT_W];
            assign lat_legal[gi] = (lat_f[gi] != '0) && (lat_f[gi] <= LAT_W'(MAX_LAT));
            always_comb begin
                busy = 1'b0;
                for (int k = 1; k < MAX_LAT; k++) begin
                    if (lat_f[gi] == LAT_W'(k) && slot_reg[k].valid) begin
                        busy = 1'b1;
                    end
                end
            end
            assign target_busy[gi] = busy;
        end
    endgenerate

    assign elig = insn_ready & lat_legal & ~target_busy;
    assign req  = flush ? '0 : elig;

    issue_cdb_scheduler_rr_arbiter #(
        .NUM_RS   (NUM_RS),
        .RS_IDX_W (RS_IDX_W)
    ) u_arb (
        .req       (req),
        .ptr       (rr_ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign issue = grant;
    assign lat_g = lat_f[grant_idx];

    assign head_owner   = slot_reg[0].owner[RS_IDX_W-1:0];
    assign wakeup_int   = slot_reg[0].valid && !flush;
    assign wakeup       = wakeup_int;
    assign wakeup_tag   = wakeup_int ? fu_result_tag[head_owner*ROB_TAG_LEN +: ROB_TAG_LEN] : '0;
    assign wakeup_value = wakeup_int ? fu_result_value[head_owner*XLEN +: XLEN] : '0;
    assign wakeup_src   = wakeup_int ? head_owner : '0;

    assign err_event      = (wakeup_int && !fu_result_valid[head_owner]) || |(insn_ready & ~lat_legal);
    assign conflict_event = |insn_ready && !any_grant && !flush;

    // Shift toward the CDB head, then drop the new grant into its reserved slot.
    always_comb begin
        for (int k = 0; k < MAX_LAT - 1; k++) begin
            slot_next[k] = slot_reg[k+1];
        end
        slot_next[MAX_LAT-1] = '0;
        for (int k = 0; k < MAX_LAT; k++) begin
            if (any_grant && lat_g == LAT_W'(k + 1)) begin
                slot_next[k].valid = 1'b1;
                slot_next[k].owner = OWNER_W'(grant_idx);
            end
        end
        rr_ptr_next = rr_ptr_reg;
        if (any_grant) begin
            rr_ptr_next = (grant_idx == RS_IDX_W'(NUM_RS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < MAX_LAT; k++) begin
                slot_reg[k] <= '0;
            end
            rr_ptr_reg       <= '0;
            conflict_cnt_reg <= '0;
            protocol_err_reg <= 1'b0;
        end else begin
            if (flush) begin
                for (int k = 0; k < MAX_LAT; k++) begin
                    slot_reg[k] <= '0;
                end
                rr_ptr_reg <= '0;
            end else begin
                for (int k = 0; k < MAX_LAT; k++) begin
                    slot_reg[k] <= slot_next[k];
                end
                rr_ptr_reg <= rr_ptr_next;
            end
            if (conflict_event && conflict_cnt_reg != 16'hFFFF) begin
                conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
            end
            if (err_event) begin
                protocol_err_reg <= 1'b1;
            end
        end
    end

    assign conflict_cnt = conflict_cnt_reg;
    assign protocol_err = protocol_err_reg;
endmodule

// File: tb/tb_issue_cdb_scheduler.sv
// Directed vector table, hand-written reset/flush sequences, then random stimulus against a due-cycle model.
module tb_issue_cdb_scheduler;
    import issue_cdb_scheduler_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int ML = 4;
    localparam int LW = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic [N-1:0]      insn_ready = '0;
    logic [N*LW-1:0]   fu_lat = '0;
    logic [N-1:0]      fu_result_valid = '0;
    logic [N*ROB_TAG_LEN-1:0] fu_result_tag = '0;
    logic [N*XLEN-1:0] fu_result_value = '0;
    logic [N-1:0]      issue;
    logic              wakeup;
    logic [ROB_TAG_LEN-1:0] wakeup_tag;
    logic [XLEN-1:0]   wakeup_value;
    logic [IW-1:0]     wakeup_src;
    logic              protocol_err;
    logic [15:0]       conflict_cnt;

    int tests = 0;
    int failed = 0;

    issue_cdb_scheduler #(.NUM_RS(N), .RS_IDX_W(IW), .MAX_LAT(ML), .LAT_W(LW)) dut (
        .clk(clk), .reset(reset), .flush(flush), .insn_ready(insn_ready), .fu_lat(fu_lat),
        .fu_result_valid(fu_result_valid), .fu_result_tag(fu_result_tag), .fu_result_value(fu_result_value),
        .issue(issue), .wakeup(wakeup), .wakeup_tag(wakeup_tag), .wakeup_value(wakeup_value),
        .wakeup_src(wakeup_src), .protocol_err(protocol_err), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [3:0]  rdy;
        logic [11:0] lat;
        logic [3:0]  frv;
        logic        fl;
        logic [3:0]  e_issue;
        logic        e_wake;
        logic [1:0]  e_src;
        logic [5:0]  e_tag;
        logic [31:0] e_val;
        logic [15:0] e_cnt;
        logic        e_perr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, logic [3:0] rdy, logic [11:0] lat, logic [3:0] frv, logic fl,
                                logic [3:0] ei, logic ew, logic [1:0] es, logic [5:0] et,
                                logic [31:0] ev, logic [15:0] ec, logic ep);
        vec_t v;
        v.rst = r; v.rdy = rdy; v.lat = lat; v.frv = frv; v.fl = fl;
        v.e_issue = ei; v.e_wake = ew; v.e_src = es; v.e_tag = et; v.e_val = ev; v.e_cnt = ec; v.e_perr = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string t, input logic [3:0] ei, input logic ew, input logic [1:0] es,
                             input logic [5:0] et, input logic [31:0] ev, input logic [15:0] ec, input logic ep);
        check($sformatf("%s.issue", t), 32'(issue), 32'(ei));
        check($sformatf("%s.wakeup", t), 32'(wakeup), 32'(ew));
        check($sformatf("%s.src", t), 32'(wakeup_src), 32'(es));
        check($sformatf("%s.tag", t), 32'(wakeup_tag), 32'(et));
        check($sformatf("%s.value", t), wakeup_value, ev);
        check($sformatf("%s.conflict_cnt", t), 32'(conflict_cnt), 32'(ec));
        check($sformatf("%s.protocol_err", t), 32'(protocol_err), 32'(ep));
    endtask

    // Leaves time at posedge+1 with reset released.
    task automatic apply_reset();
        reset = 1'b1;
        insn_ready = '0;
        flush = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Reference model: a result granted at cycle c with latency L is due on the CDB at cycle c+L.
    bit m_due_v [16];
    int m_due_o [16];
    int m_rr, m_cyc, m_cnt;
    bit m_perr;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_due_v[i] = 1'b0;
            m_due_o[i] = 0;
        end
        m_rr = 0; m_cyc = 0; m_cnt = 0; m_perr = 1'b0;
    endtask

    task automatic model_cycle(input int n);
        int L [N];
        int g, o;
        bit wake, illegal;
        logic [3:0] ei;
        logic [5:0] et;
        logic [31:0] ev;
        g = -1;
        illegal = 1'b0;
        for (int i = 0; i < N; i++) begin
            L[i] = int'(fu_lat[i*LW +: LW]);
            if (insn_ready[i] && (L[i] < 1 || L[i] > ML)) illegal = 1'b1;
        end
        for (int off = 0; off < N; off++) begin
            int i;
            i = (m_rr + off) % N;
            if (g < 0 && !flush && insn_ready[i] && L[i] >= 1 && L[i] <= ML && !m_due_v[(m_cyc + L[i]) % 16])
                g = i;
        end
        ei = (g >= 0) ? 4'(1 << g) : 4'h0;
        wake = m_due_v[m_cyc % 16] && !flush;
        o = m_due_o[m_cyc % 16];
        et = wake ? fu_result_tag[o*ROB_TAG_LEN +: ROB_TAG_LEN] : '0;
        ev = wake ? fu_result_value[o*XLEN +: XLEN] : '0;
        check_all($sformatf("rnd%0d", n), ei, wake, wake ? 2'(o) : 2'd0, et, ev, 16'(m_cnt), m_perr);
        if ((wake && !fu_result_valid[o]) || illegal) m_perr = 1'b1;
        if (insn_ready != 0 && g < 0 && !flush && m_cnt < 65535) m_cnt++;
        m_due_v[m_cyc % 16] = 1'b0;
        if (flush) begin
            for (int i = 0; i < 16; i++) m_due_v[i] = 1'b0;
            m_rr = 0;
        end else if (g >= 0) begin
            m_due_v[(m_cyc + L[g]) % 16] = 1'b1;
            m_due_o[(m_cyc + L[g]) % 16] = g;
            m_rr = (g + 1) % N;
        end
        m_cyc++;
    endtask

    initial begin
        // reset, 1-RS latency-1 wakeup
        vecs.push_back(mk(1, 4'b0001, 12'h249, 4'hF, 0, 4'b0001, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 12'h249, 4'hF, 0, 4'b0000, 1, 0, 5, 32'hAB, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 12'h249, 4'hF, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
        // all ready, all latency 1: rotating grants
        vecs.push_back(mk(1, 4'b1111, 12'h249, 4'hF, 0, 4'b0001, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 12'h249, 4'hF, 0, 4'b0010, 1, 0, 5, 32'hAB, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 12'h249, 4'hF, 0, 4'b0100, 1, 1, 6, 32'hBC, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 12'h249, 4'hF, 0, 4'b1000, 1, 2, 7, 32'hCD, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 12'h249, 4'hF, 0, 4'b0001, 1, 3, 8, 32'hDE, 0, 0));
        // FU0 lat 2 blocks FU1 lat 1 for one cycle
        vecs.push_back(mk(1, 4'b0001, 12'h24A, 4'hF, 0, 4'b0001, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0010, 12'h24A, 4'hF, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0010, 12'h24A, 4'hF, 0, 4'b0010, 1, 0, 5, 32'hAB, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 12'h24A, 4'hF, 0, 4'b0000, 1, 1, 6, 32'hBC, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 12'h24A, 4'hF, 0, 4'b0000, 0, 0, 0, 0, 1, 0));
        // FU2 lat 4 squashed by flush
        vecs.push_back(mk(1, 4'b0100, 12'h309, 4'hF, 0, 4'b0100, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 12'h309, 4'hF, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 12'h309, 4'hF, 1, 4'b0000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 12'h309, 4'hF, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 12'h309, 4'hF, 0, 4'b0001, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 12'h309, 4'hF, 0, 4'b0000, 1, 0, 5, 32'hAB, 0, 0));
        // FU3 illegal latency 0
        vecs.push_back(mk(1, 4'b1000, 12'h049, 4'hF, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1001, 12'h049, 4'hF, 0, 4'b0001, 0, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 4'b1010, 12'h049, 4'hF, 0, 4'b0010, 1, 0, 5, 32'hAB, 1, 1));
        vecs.push_back(mk(0, 4'b1000, 12'h049, 4'hF, 0, 4'b0000, 1, 1, 6, 32'hBC, 1, 1));
        vecs.push_back(mk(0, 4'b0000, 12'h049, 4'hF, 0, 4'b0000, 0, 0, 0, 0, 2, 1));
        // result missing at the head
        vecs.push_back(mk(1, 4'b0001, 12'h249, 4'hE, 0, 4'b0001, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 12'h249, 4'hE, 0, 4'b0000, 1, 0, 5, 32'hAB, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 12'h249, 4'hE, 0, 4'b0000, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 4'b0000, 12'h249, 4'hE, 0, 4'b0000, 0, 0, 0, 0, 0, 1));

        fu_result_tag   = {6'd8, 6'd7, 6'd6, 6'd5};
        fu_result_value = {32'hDE, 32'hCD, 32'hBC, 32'hAB};
        #2;
        check("reset.issue", 32'(issue), 32'h0);
        check("reset.wakeup", 32'(wakeup), 32'h0);
        check("reset.tag", 32'(wakeup_tag), 32'h0);
        apply_reset();

        foreach (vecs[i]) begin
            if (vecs[i].rst) apply_reset();
            insn_ready = vecs[i].rdy;
            fu_lat = vecs[i].lat;
            fu_result_valid = vecs[i].frv;
            flush = vecs[i].fl;
            #4;
            check_all($sformatf("vec%0d", i), vecs[i].e_issue, vecs[i].e_wake, vecs[i].e_src,
                      vecs[i].e_tag, vecs[i].e_val, vecs[i].e_cnt, vecs[i].e_perr);
            @(posedge clk);
            #1;
        end

        // Sticky error, then async reset mid-cycle discards a pending latency-3 result.
        flush = 1'b0;
        insn_ready = 4'b0001;
        fu_lat = 12'h24B;
        fu_result_valid = 4'hE;
        #4;
        check("pend.issue", 32'(issue), 32'h1);
        check("pend.perr_sticky", 32'(protocol_err), 32'h1);
        @(posedge clk);
        #1;
        insn_ready = 4'b0000;
        #2;
        reset = 1'b1;
        #1;
        check("async_rst.perr", 32'(protocol_err), 32'h0);
        check("async_rst.wakeup", 32'(wakeup), 32'h0);
        check("async_rst.cnt", 32'(conflict_cnt), 32'h0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            #4;
            check($sformatf("discard%0d.wakeup", c), 32'(wakeup), 32'h0);
            @(posedge clk);
            #1;
        end

        // Random stimulus against the model.
        apply_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            int r;
            if (n % 300 == 299) begin
                apply_reset();
                model_reset();
            end
            insn_ready = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                r = $urandom_range(0, 15);
                fu_lat[i*LW +: LW] = (r == 0) ? 3'd0 : (r == 1) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(1, 4));
                fu_result_valid[i] = ($urandom_range(0, 49) != 0);
            end
            flush = ($urandom_range(0, 29) == 0);
            fu_result_tag = 24'($urandom);
            fu_result_value = {$urandom, $urandom, $urandom, $urandom};
            #4;
            model_cycle(n);
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/issue_cdb_scheduler.md
Name: issue_cdb_scheduler

Overview:
Issue/wakeup controller for the reservation stations (RS). Each cycle it grants at most one ready RS its `issue` strobe, picked by round-robin. Grants are arbitrated so that no two results reach the single common data bus (CDB) in the same cycle. It tracks each granted op's fixed FU latency in a slot vector and drives `wakeup` / `wakeup_tag` / `wakeup_value` back to all RSs in the cycle the result is due.

Parameters:
- NUM_RS, 4, number of reservation stations / FUs served (any value >= 2, need not be a power of 2).
- RS_IDX_W, 2, width of an RS index; ceil(log2(NUM_RS)).
- MAX_LAT, 4, largest legal FU latency in cycles; also the number of CDB slots.
- LAT_W, 3, width of one latency field; must hold MAX_LAT.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-high reset.
- flush, in, 1, synchronous squash of all pending schedule state.
- insn_ready, in, NUM_RS, per-RS "has a ready instruction" (combinational from the RS).
- fu_lat, in, NUM_RS*LAT_W, static per-FU latency; field i is bits [i*LAT_W +: LAT_W].
- fu_result_valid, in, NUM_RS, FU i presents a result this cycle.
- fu_result_tag, in, NUM_RS*ROB_TAG_LEN, per-FU destination ROB tag.
- fu_result_value, in, NUM_RS*XLEN, per-FU result value.
- issue, out, NUM_RS, one-hot (or zero) grant to the RSs; combinational.
- wakeup, out, 1, CDB broadcast valid.
- wakeup_tag, out, ROB_TAG_LEN, broadcast tag.
- wakeup_value, out, XLEN, broadcast value.
- wakeup_src, out, RS_IDX_W, index of the FU owning the broadcast.
- protocol_err, out, 1, sticky error flag.
- conflict_cnt, out, 16, saturating count of cycles with a ready RS but no grant.

Behaviour:
- State:
  - slot[0..MAX_LAT-1], each entry {valid, owner[RS_IDX_W]}.
  - rr_ptr[RS_IDX_W].
  - conflict_cnt.
  - protocol_err.
- Reset (async): all slots invalid, rr_ptr=0, conflict_cnt=0, protocol_err=0. As a result issue=0 and wakeup=0, and wakeup_tag/value/src=0.
- Legal latency: L_i = fu_lat[i] in 1..MAX_LAT. If L_i is illegal, RS i is never granted and protocol_err is set at the next edge while insn_ready[i]=1.
- Eligibility: elig[i] = insn_ready[i] && legal L_i && (L_i==MAX_LAT || !slot[L_i].valid). The check is against the slot that shifts into position L_i-1 at the edge.
- Grant selection:
  - Pick the first elig index starting at rr_ptr, scanning upward and wrapping modulo NUM_RS.
  - issue[g]=1, all other bits 0.
  - No grant (issue=0) when flush=1 or no index is eligible.
- Edge update, in this order:
  - Shift: slot[k] <= slot[k+1] for k < MAX_LAT-1; slot[MAX_LAT-1] <= invalid.
  - On grant: slot[L_g-1] <= {1, g}, and rr_ptr <= (g+1) mod NUM_RS.
- Wakeup is combinational from slot[0]:
  - wakeup = slot[0].valid && !flush.
  - tag, value and src are muxed from owner o = slot[0].owner; they are 0 when wakeup=0.
  - Latency 1: wakeup is asserted in the cycle right after the issue edge. Latency L: wakeup is asserted L-1 cycles later.
- protocol_err is sticky and is set at the edge when either condition holds:
  - wakeup=1 and fu_result_valid[o]=0.
  - An illegal-latency request (see above).
- conflict_cnt: +1 at an edge when |insn_ready=1, no grant, and flush=0; it saturates at 0xFFFF.
- Flush: at the edge, all slots are cleared and rr_ptr <= 0. In the flush cycle, wakeup and issue are forced to 0.
- Simultaneous grant and slot[0] broadcast is allowed. Shift and insert never collide, because eligibility guarantees the target slot is empty.
- Reset mid-operation discards all pending slots immediately; no wakeup is emitted for them.

Decomposition:
- Shared package, alongside the existing ROB_TAG_LEN / XLEN:
  - typedef CDB_SLOT {logic valid; logic [RS_IDX_W-1:0] owner;}.
  - Localparam default for MAX_LAT.
- One sub-module: rr_arbiter (NUM_RS requests in, rotating pointer in, one-hot grant out, plus grant index and any_grant). It is purely combinational and instantiated once.

Test Plan:
- Reset, then insn_ready=4'b0001, fu_lat all 1, fu_result tag=5 / value=0xAB on FU0 -> issue=0001 the same cycle; wakeup=1, tag=5, value=0xAB, src=0 exactly one cycle later; protocol_err=0.
- insn_ready=4'b1111 held, all latencies 1 -> grants go 0,1,2,3,0 on consecutive cycles; conflict_cnt stays 0.
- fu_lat={FU1:1, FU0:2}; FU0 granted at cycle 0, then only FU1 ready at cycle 1 -> FU1 is blocked at cycle 1 (slot taken), conflict_cnt=1; FU1 is granted at cycle 2; wakeups occur at cycles 2 and 3 with no overlap.
- Grant FU2 with latency 4, assert flush for one cycle two cycles later -> no wakeup ever appears for FU2; issue=0 during flush; rr_ptr=0 afterwards (the next grant with all ready is RS0).
- fu_lat[3]=0 with insn_ready[3]=1 -> RS3 is never granted; protocol_err=1 after the first edge; other RSs are still granted.
- Slot reaches head while fu_result_valid[owner]=0 -> wakeup is still asserted; protocol_err=1 and stays 1 until reset (asserted asynchronously mid-cycle, which clears it immediately).
